m_bus_ctrl: RTL and testbench

M_BUS_CTRL -- requirements
Module: m_bus_ctrl

---
 rtl/m_bus_ctrl_pkg.sv | 18 +
 rtl/m_bus_ctrl_decode.sv | 18 +
 rtl/m_bus_ctrl.sv | 112 +++++++++++
 tb/tb_m_bus_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/m_bus_ctrl_pkg.sv
// m_bus_ctrl_pkg: shared FSM state codes and slave address ranges for the M-stage bus controller
package m_bus_ctrl_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;
  localparam logic [31:0] DM_LO  = 32'h0000_0000;
  localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TC1_LO = 32'h0000_7F10;
  localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
  localparam logic [31:0] INT_LO = 32'h0000_7F20;
  localparam logic [31:0] INT_HI = 32'h0000_7F23;
  function automatic logic in_rng(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/m_bus_ctrl_decode.sv
// m_bus_decode: address decode to one-hot {INT,TC1,TC0,DM}; peripherals accept only full-word stores
module m_bus_decode
  import m_bus_ctrl_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [3:0]  i_byteen,
  output logic [3:0]  o_sel,
  output logic        o_hit
);
  logic w_word;
  assign w_word = !i_we || (i_byteen == 4'b1111);
  assign o_sel  = {in_rng(i_addr, INT_LO, INT_HI) && w_word,
                   in_rng(i_addr, TC1_LO, TC1_HI) && w_word,
                   in_rng(i_addr, TC0_LO, TC0_HI) && w_word,
                   in_rng(i_addr, DM_LO, DM_HI)};
  assign o_hit  = |o_sel;
endmodule

// File: rtl/m_bus_ctrl.sv
// m_bus_ctrl: M-stage memory bus controller (IDLE/ACCESS/RESP/ERR) with flush abort.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module m_bus_ctrl
  import m_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_byteen,
  input  logic        m_flush,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic [3:0]  s_sel,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byteen,
  input  logic        s_ack,
  input  logic [31:0] s_rdata
);
  logic [1:0]  r_state;
  logic        r_abort;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [3:0]  w_sel;
  logic        w_hit;
  logic        w_go;
  logic        w_to;
  logic        w_abort;
  m_bus_decode u_dec (
    .i_addr  (m_addr),
    .i_we    (m_we),
    .i_byteen(m_byteen),
    .o_sel   (w_sel),
    .o_hit   (w_hit)
  );
`ifdef BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  assign w_to = !s_ack && (r_cnt == 8'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign w_to = 1'b0;
`endif
  assign w_go    = (r_state == ST_IDLE) && m_req && !m_flush;
  assign w_abort = r_abort || m_flush;
  assign m_stall = w_go || (r_state == ST_ACCESS);
  assign m_err   = r_err;
  assign m_rdata = r_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_abort  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      s_sel    <= '0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_byteen <= '0;
`ifdef BUS_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_go && w_hit) begin
          s_req    <= 1'b1;
          s_sel    <= w_sel;
          s_we     <= m_we;
          s_addr   <= m_addr;
          s_wdata  <= m_wdata;
          s_byteen <= m_byteen;
          r_abort  <= 1'b0;
          r_state  <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end else if (w_go) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
          r_state <= ST_ERR;
        end
        ST_ACCESS: if (s_ack) begin
          s_req   <= 1'b0;
          r_abort <= 1'b0;
          r_rdata <= w_abort ? r_rdata : s_rdata;
          r_state <= w_abort ? ST_IDLE : ST_RESP;
        end else if (w_to) begin
          s_req   <= 1'b0;
          r_abort <= 1'b0;
          r_err   <= 1'b1;
          r_rdata <= '0;
          r_state <= ST_ERR;
        end else begin
          r_abort <= w_abort;
`ifdef BUS_TIMEOUT_EN
          r_cnt   <= r_cnt + 8'd1;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_bus_ctrl.sv
// tb_m_bus_ctrl: directed self-checking bench for m_bus_ctrl (TIMEOUT_CYC=4)
module tb_m_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_req = 1'b0, m_we = 1'b0, m_flush = 1'b0, s_ack = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, s_rdata = '0;
  logic [3:0]  m_byteen = '0;
  logic        m_stall, m_err, s_req, s_we;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [3:0]  s_sel, s_byteen;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  m_bus_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_byteen(m_byteen), .m_flush(m_flush), .m_stall(m_stall),
    .m_rdata(m_rdata), .m_err(m_err), .s_sel(s_sel), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen), .s_ack(s_ack),
    .s_rdata(s_rdata)
  );
  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic fl,
                       input logic ack, input logic [31:0] rd);
    @(posedge clk);
    #1;
    m_req = req; m_we = we; m_addr = addr; m_wdata = wd; m_byteen = be;
    m_flush = fl; s_ack = ack; s_rdata = rd;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    idle();
    idle();
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_ssel", 32'(s_sel), 32'h0);
    chk("rst_saddr", s_addr, 32'h0);
    chk("rst_merr", 32'(m_err), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_stall", 32'(m_stall), 32'h0);
    reset = 1'b0;
    // load DM 0x0004, ack on second ACCESS cycle
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("ld_stall0", 32'(m_stall), 32'h1);
    chk("ld_sreq0", 32'(s_req), 32'h0);
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("ld_stall1", 32'(m_stall), 32'h1);
    chk("ld_sreq1", 32'(s_req), 32'h1);
    chk("ld_ssel", 32'(s_sel), 32'h1);
    chk("ld_saddr", s_addr, 32'h4);
    chk("ld_swe", 32'(s_we), 32'h0);
    drive(1, 0, 32'h4, 0, 0, 0, 1, 32'h1234_5678);
    chk("ld_stall2", 32'(m_stall), 32'h1);
    chk("ld_sreq2", 32'(s_req), 32'h1);
    idle();
    chk("ld_resp_stall", 32'(m_stall), 32'h0);
    chk("ld_resp_rdata", m_rdata, 32'h1234_5678);
    chk("ld_resp_sreq", 32'(s_req), 32'h0);
    chk("ld_resp_err", 32'(m_err), 32'h0);
    idle();
    // partial-word store to TC0 is a decode miss
    drive(1, 1, 32'h7F04, 32'hAAAA_BBBB, 4'b0011, 0, 0, 0);
    chk("st_miss_stall", 32'(m_stall), 32'h1);
    idle();
    chk("st_miss_err", 32'(m_err), 32'h1);
    chk("st_miss_sreq", 32'(s_req), 32'h0);
    chk("st_miss_stall_err", 32'(m_stall), 32'h0);
    chk("st_miss_rdata", m_rdata, 32'h0);
    idle();
    chk("st_miss_err_clr", 32'(m_err), 32'h0);
    chk("st_miss_sreq2", 32'(s_req), 32'h0);
    // load just past DM
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0);
    idle();
    chk("ld3000_err", 32'(m_err), 32'h1);
    chk("ld3000_sreq", 32'(s_req), 32'h0);
    idle();
    // load INT with immediate ack
    drive(1, 0, 32'h7F20, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h7F20, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("int_ssel", 32'(s_sel), 32'h8);
    chk("int_sreq", 32'(s_req), 32'h1);
    chk("int_stall", 32'(m_stall), 32'h1);
    idle();
    chk("int_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("int_stall_resp", 32'(m_stall), 32'h0);
    chk("int_err", 32'(m_err), 32'h0);
    // flush in IDLE ignores request; stray ack in IDLE ignored
    drive(1, 0, 32'h4, 0, 0, 1, 0, 0);
    chk("fl_idle_stall", 32'(m_stall), 32'h0);
    drive(0, 0, 32'h0, 0, 0, 0, 1, 32'h55);
    chk("fl_idle_sreq", 32'(s_req), 32'h0);
    idle();
    chk("ack_idle_sreq", 32'(s_req), 32'h0);
    chk("ack_idle_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("ack_idle_err", 32'(m_err), 32'h0);
    // store TC1, flushed in first ACCESS cycle, ack three cycles later
    drive(1, 1, 32'h7F10, 32'hA5A5_0F0F, 4'hF, 0, 0, 0);
    chk("ab_stall0", 32'(m_stall), 32'h1);
    drive(0, 0, 32'h0, 0, 0, 1, 0, 0);
    chk("ab_sreq", 32'(s_req), 32'h1);
    chk("ab_ssel", 32'(s_sel), 32'h4);
    chk("ab_swe", 32'(s_we), 32'h1);
    chk("ab_saddr", s_addr, 32'h7F10);
    chk("ab_swdata", s_wdata, 32'hA5A5_0F0F);
    chk("ab_sbe", 32'(s_byteen), 32'hF);
    chk("ab_stall1", 32'(m_stall), 32'h1);
    idle();
    chk("ab_stall2", 32'(m_stall), 32'h1);
    idle();
    drive(0, 0, 32'h0, 0, 0, 0, 1, 32'h1111_1111);
    chk("ab_sreq_ack", 32'(s_req), 32'h1);
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("ab_idle_stall", 32'(m_stall), 32'h1);
    chk("ab_idle_sreq", 32'(s_req), 32'h0);
    chk("ab_idle_err", 32'(m_err), 32'h0);
    drive(1, 0, 32'h4, 0, 0, 0, 1, 32'h0);
    idle();
    idle();
    // no ack: timeout or indefinite wait
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
      chk("to_sreq", 32'(s_req), 32'h1);
    end
    idle();
    chk("to_err", 32'(m_err), 32'h1);
    chk("to_sreq_drop", 32'(s_req), 32'h0);
    idle();
    chk("to_err_clr", 32'(m_err), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
      chk("wait_sreq", 32'(s_req), 32'h1);
      chk("wait_err", 32'(m_err), 32'h0);
    end
    drive(1, 0, 32'h8, 0, 0, 0, 1, 32'h0BAD_F00D);
    idle();
    chk("wait_rdata", m_rdata, 32'h0BAD_F00D);
    idle();
`endif
    // reset mid-ACCESS
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("rm_sreq_pre", 32'(s_req), 32'h1);
    reset = 1'b1;
    idle();
    chk("rm_sreq", 32'(s_req), 32'h0);
    chk("rm_ssel", 32'(s_sel), 32'h0);
    chk("rm_saddr", s_addr, 32'h0);
    chk("rm_err", 32'(m_err), 32'h0);
    chk("rm_rdata", m_rdata, 32'h0);
    chk("rm_stall", 32'(m_stall), 32'h0);
    reset = 1'b0;
    idle();
    chk("rm_err2", 32'(m_err), 32'h0);
    // boundaries: last DM word hits, first address past TC0 misses
    drive(1, 0, 32'h2FFC, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h2FFC, 0, 0, 0, 1, 32'hCAFE_F00D);
    chk("dmhi_ssel", 32'(s_sel), 32'h1);
    idle();
    chk("dmhi_rdata", m_rdata, 32'hCAFE_F00D);
    drive(1, 0, 32'h7F0C, 0, 0, 0, 0, 0);
    idle();
    chk("tc0hi_err", 32'(m_err), 32'h1);
    chk("tc0hi_sreq", 32'(s_req), 32'h0);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
